// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner types and constants for the two-port memory arbiter
package mem_arb_pkg;
    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {OWN_IF, OWN_LS} owner_t;
    localparam logic [3:0] BE_ALL = 4'hF;
endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: fetch, load/store and memory-macro signals of the memory arbiter
interface mem_arb_if #(parameter int AW = 13, parameter int DW = 32);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          ls_req;
    logic          ls_we;
    logic [3:0]    ls_be;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arb_rr_arb2.sv
// rr_arb2: two-way round-robin picker, bit 0 = fetch, bit 1 = load/store
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output logic [1:0] gnt
);
    always_comb gnt = &req ? (last == OWN_IF ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/mem_arb.sv
// mem_arb: shares one fixed-latency single-port memory between fetch and load/store, round-robin
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int AW  = 13,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic     clk,
    input  logic     rst,
    mem_arb_if.slave bus
);
    localparam int CW = $clog2(LAT + 1);

    state_t        state;
    owner_t        owner;
    owner_t        last;
    logic [CW-1:0] cnt;
    logic          done;
    logic          ready;
    logic [1:0]    gnt;

    // the completing cycle also accepts the next transaction, so responses and grants can overlap
    assign done  = state == BUSY && cnt == CW'(1);
    assign ready = rst && (state == IDLE || done);

    rr_arb2 u_rr (
        .req  ({bus.ls_req, bus.if_req} & {2{ready}}),
        .last (last),
        .gnt  (gnt)
    );

    assign bus.if_gnt    = gnt[0];
    assign bus.ls_gnt    = gnt[1];
    assign bus.mem_en    = |gnt;
    assign bus.mem_we    = gnt[1] & bus.ls_we;
    assign bus.mem_be    = gnt[1] ? bus.ls_be : gnt[0] ? BE_ALL : 4'h0;
    assign bus.mem_addr  = gnt[1] ? bus.ls_addr : gnt[0] ? bus.if_addr : AW'(0);
    assign bus.mem_wdata = gnt[1] ? bus.ls_wdata : DW'(0);

    assign bus.if_rvalid = done && owner == OWN_IF;
    assign bus.ls_rvalid = done && owner == OWN_LS;
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : DW'(0);
    assign bus.ls_rdata  = bus.ls_rvalid ? bus.mem_rdata : DW'(0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            owner <= OWN_IF;
            last  <= OWN_IF;
        end else if (|gnt) begin
            state <= BUSY;
            cnt   <= CW'(LAT);
            owner <= owner_t'(gnt[1]);
            last  <= owner_t'(gnt[1]);
        end else if (state == BUSY) begin
            state <= done ? IDLE : BUSY;
            cnt   <= cnt - CW'(1);
        end
    end
endmodule
